// File: rtl/tdm_mux_sequencer_pkg.sv
// tdm_mux_pkg: shared state encoding, width helper and default parameters
package tdm_mux_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, DONE} state_e;
  localparam int NCH_DEF = 64;
  localparam int W_DEF = 8;
  localparam int DWELL_W_DEF = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/tdm_mux_sequencer_if.sv
// tdm_mux_sequencer_if: source bank, request controls and tagged output stream
interface tdm_mux_sequencer_if import tdm_mux_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W = W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) ();
  localparam int SELW = clog2(NCH);
  logic [NCH*W-1:0] in_data;
  logic mode;
  logic [SELW-1:0] sel_in;
  logic [NCH-1:0] ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic start;
  logic [W-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic scan_done;
  modport master (
    output in_data, mode, sel_in, ch_mask, dwell, start, out_ready,
    input out_data, out_ch, out_valid, busy, scan_done
  );
  modport slave (
    input in_data, mode, sel_in, ch_mask, dwell, start, out_ready,
    output out_data, out_ch, out_valid, busy, scan_done
  );
endinterface

// File: rtl/tdm_mux_sequencer_prio_enc.sv
// mux_prio_enc: index of the lowest set bit plus an any-set flag
module mux_prio_enc #(
  parameter int NCH = 64,
  parameter int SELW = 6
) (
  input logic [NCH-1:0] vec,
  output logic [SELW-1:0] idx,
  output logic any_set
);
  assign any_set = |vec;
  // scan from the top so the lowest set bit is the last, winning assignment
  always_comb begin
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) if (vec[i]) idx = SELW'(i);
  end
endmodule

// File: rtl/tdm_mux_sequencer.sv
// tdm_mux_sequencer: registered N:1 mux with single-shot and masked-scan sequencing
module tdm_mux_sequencer import tdm_mux_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W = W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic clk,
  input logic rst,
  tdm_mux_sequencer_if.slave bus
);
  localparam int SELW = clog2(NCH);
  localparam logic [NCH-1:0] ONE = NCH'(1);
  state_e state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d, new_mask, mask_rem, enc_vec;
  logic [SELW-1:0] ptr_q, ptr_d, enc_idx, out_ch_q, out_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d, enc_any;
  // an out-of-range sel_in shifts the one-hot bit off the end, leaving an empty mask
  assign new_mask = bus.mode ? bus.ch_mask : ONE << bus.sel_in;
  assign mask_rem = mask_q & ~(ONE << ptr_q);
  assign enc_vec = (state_q == IDLE) ? new_mask : mask_rem;
  mux_prio_enc #(.NCH(NCH), .SELW(SELW)) u_enc (.vec(enc_vec), .idx(enc_idx), .any_set(enc_any));
  // next-state and registered-output logic of the sequencer
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    dwell_d = dwell_q;
    out_data_d = out_data_q;
    out_ch_d = out_ch_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (bus.start) begin
        dwell_d = bus.dwell;
        mask_d = new_mask;
        ptr_d = enc_idx;
        cnt_d = bus.dwell;
        state_d = enc_any ? SETTLE : DONE;
      end
      SETTLE: if (cnt_q == '0) begin
        out_data_d = bus.in_data[int'(ptr_q)*W +: W];
        out_ch_d = ptr_q;
        out_valid_d = 1'b1;
        state_d = PRESENT;
      end else cnt_d = cnt_q - 1'b1;
      PRESENT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        mask_d = mask_rem;
        ptr_d = enc_idx;
        cnt_d = dwell_q;
        state_d = enc_any ? SETTLE : DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      dwell_q <= '0;
      out_data_q <= '0;
      out_ch_q <= '0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      dwell_q <= dwell_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.out_data = out_data_q;
  assign bus.out_ch = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy = busy_q;
  assign bus.scan_done = done_q;
endmodule
